// File: rtl/knob_step_decoder_pkg.sv
// Shared defaults, quadrature encodings and the transition classifier for the
// rotary-encoder step decoder.
package knob_step_decoder_pkg;

  localparam int DB_CYCLES_DEF        = 100000;
  localparam int STEPS_PER_DETENT_DEF = 4;
  localparam int LED_HOLD_CYCLES_DEF  = 25000000;

  typedef enum logic [1:0] {
    Q_00 = 2'b00,
    Q_01 = 2'b01,
    Q_11 = 2'b11,
    Q_10 = 2'b10
  } quad_state_e;

  typedef enum logic [1:0] {
    MV_NONE = 2'd0,
    MV_CW   = 2'd1,
    MV_CCW  = 2'd2,
    MV_ERR  = 2'd3
  } quad_move_e;

  function automatic quad_state_e quad_cw_next(input quad_state_e cur);
    quad_state_e nxt;
    case (cur)
      Q_00:    nxt = Q_01;
      Q_01:    nxt = Q_11;
      Q_11:    nxt = Q_10;
      default: nxt = Q_00;
    endcase
    return nxt;
  endfunction

  // Both bits flipping at once cannot be ordered, so it is reported as an error.
  function automatic quad_move_e quad_move(input quad_state_e prev, input quad_state_e cur);
    quad_move_e mv;
    if (prev == cur)                          mv = MV_NONE;
    else if ((prev ^ cur) == 2'b11)           mv = MV_ERR;
    else if (cur == quad_cw_next(prev))       mv = MV_CW;
    else                                      mv = MV_CCW;
    return mv;
  endfunction

endpackage

// File: rtl/knob_debounce_filter.sv
// One encoder channel: two-flop synchronizer followed by a stability counter
// that accepts a new level only after DB_CYCLES consecutive differing cycles.
module knob_debounce_filter
  import knob_step_decoder_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/knob_step_decoder.sv
// Rotary-encoder decoder: debounced quadrature -> detent step pulses, a wrapping
// 5-bit position and stretched direction LEDs.
module knob_step_decoder
  import knob_step_decoder_pkg::*;
#(
  parameter int DB_CYCLES        = DB_CYCLES_DEF,
  parameter int STEPS_PER_DETENT = STEPS_PER_DETENT_DEF,
  parameter int LED_HOLD_CYCLES  = LED_HOLD_CYCLES_DEF
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       knob_a,
  input  logic       knob_b,
  output logic       step_inc,
  output logic       step_dec,
  output logic       quad_err,
  output logic [4:0] position,
  output logic [1:0] dir_led
);

  localparam int LW = $clog2(LED_HOLD_CYCLES + 1);
  localparam logic signed [4:0] STEP_POS = 5'(STEPS_PER_DETENT);
  localparam logic signed [4:0] STEP_NEG = -STEP_POS;

  logic        a_db, b_db;
  quad_state_e quad_cur;
  quad_move_e  mv;
  logic        busy;

  quad_state_e       quad_prev_q, quad_prev_d;
  logic signed [3:0] sub_cnt_q, sub_cnt_d;
  logic signed [4:0] sub_ext, sub_sum;
  logic              step_inc_q, step_inc_d;
  logic              step_dec_q, step_dec_d;
  logic              quad_err_q, quad_err_d;
  logic [4:0]        position_q, position_d;
  logic [LW-1:0]     led_inc_q, led_inc_d;
  logic [LW-1:0]     led_dec_q, led_dec_d;

  knob_debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk    (clk_100MHz),
    .reset  (reset),
    .raw_in (knob_a),
    .level  (a_db)
  );

  knob_debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk    (clk_100MHz),
    .reset  (reset),
    .raw_in (knob_b),
    .level  (b_db)
  );

  assign quad_cur = quad_state_e'({a_db, b_db});
  assign mv       = quad_move(quad_prev_q, quad_cur);
  // A transition arriving right after a pulse is held one cycle so pulses never abut.
  assign busy     = step_inc_q | step_dec_q | quad_err_q;

  always_comb begin
    quad_prev_d = busy ? quad_prev_q : quad_cur;
    sub_cnt_d   = sub_cnt_q;
    sub_ext     = {sub_cnt_q[3], sub_cnt_q};
    sub_sum     = sub_ext;
    step_inc_d  = 1'b0;
    step_dec_d  = 1'b0;
    quad_err_d  = 1'b0;
    position_d  = position_q;
    led_inc_d   = (led_inc_q != '0) ? led_inc_q - LW'(1) : led_inc_q;
    led_dec_d   = (led_dec_q != '0) ? led_dec_q - LW'(1) : led_dec_q;

    if (!busy) begin
      case (mv)
        MV_CW:   sub_sum = sub_ext + 5'sd1;
        MV_CCW:  sub_sum = sub_ext - 5'sd1;
        default: sub_sum = sub_ext;
      endcase

      if (mv == MV_ERR) begin
        quad_err_d = 1'b1;
        sub_cnt_d  = 4'sd0;
      end else if (sub_sum == STEP_POS) begin
        sub_cnt_d  = 4'sd0;
        step_inc_d = 1'b1;
        position_d = position_q + 5'd1;
        led_inc_d  = LW'(LED_HOLD_CYCLES);
        led_dec_d  = '0;
      end else if (sub_sum == STEP_NEG) begin
        sub_cnt_d  = 4'sd0;
        step_dec_d = 1'b1;
        position_d = position_q - 5'd1;
        led_dec_d  = LW'(LED_HOLD_CYCLES);
        led_inc_d  = '0;
      end else begin
        sub_cnt_d  = sub_sum[3:0];
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      quad_prev_q <= Q_00;
      sub_cnt_q   <= 4'sd0;
      step_inc_q  <= 1'b0;
      step_dec_q  <= 1'b0;
      quad_err_q  <= 1'b0;
      position_q  <= 5'd0;
      led_inc_q   <= '0;
      led_dec_q   <= '0;
    end else begin
      quad_prev_q <= quad_prev_d;
      sub_cnt_q   <= sub_cnt_d;
      step_inc_q  <= step_inc_d;
      step_dec_q  <= step_dec_d;
      quad_err_q  <= quad_err_d;
      position_q  <= position_d;
      led_inc_q   <= led_inc_d;
      led_dec_q   <= led_dec_d;
    end
  end

  assign step_inc = step_inc_q;
  assign step_dec = step_dec_q;
  assign quad_err = quad_err_q;
  assign position = position_q;
  assign dir_led  = {led_inc_q != '0, led_dec_q != '0};

endmodule

// File: doc/knob_step_decoder.md
KNOB_STEP_DECODER -- requirements
Module: knob_step_decoder

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 100000, the number of consecutive stable cycles needed to accept an input level (1 ms at 100 MHz).
REQ-002 The block SHALL have parameter STEPS_PER_DETENT, default 4, the number of valid quadrature transitions per emitted step.
REQ-003 The block SHALL have parameter LED_HOLD_CYCLES, default 25000000, the direction-LED stretch time in cycles.
REQ-004 The block SHALL have port clk_100MHz, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port knob_a, input, 1 bit: raw encoder channel A, asynchronous to the clock.
REQ-007 The block SHALL have port knob_b, input, 1 bit: raw encoder channel B, asynchronous to the clock.
REQ-008 The block SHALL have port step_inc, output, 1 bit: one-cycle pulse for one detent clockwise.
REQ-009 The block SHALL have port step_dec, output, 1 bit: one-cycle pulse for one detent counter-clockwise.
REQ-010 The block SHALL have port quad_err, output, 1 bit: one-cycle pulse when an illegal transition occurs.
REQ-011 The block SHALL have port position, output, 5 bits: wrapping detent counter.
REQ-012 The block SHALL have port dir_led, output, 2 bits: [1] marks recent clockwise motion and [0] marks recent counter-clockwise motion.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Debounce: a per-channel counter SHALL count while the synchronized level differs from the accepted level.
REQ-015 The counter SHALL clear to 0 on any cycle where the two levels match.
REQ-016 When the counter reaches DB_CYCLES-1, the accepted level SHALL update on the next edge and the counter SHALL clear.
REQ-017 Quadrature state SHALL be the 2-bit value {a_db, b_db}.
REQ-018 The clockwise sequence SHALL be 00->01->11->10->00, with each such transition counting +1.
REQ-019 The reverse sequence SHALL count -1 per transition.
REQ-020 A transition in which both bits change in the same cycle SHALL pulse quad_err for one cycle and clear the sub-count to 0, with no step emitted.
REQ-021 Sub-count SHALL be a signed 4-bit register.
REQ-022 When an update would make the sub-count reach +STEPS_PER_DETENT, the sub-count SHALL be set to 0 and step_inc SHALL assert on the next cycle.
REQ-023 When an update would make the sub-count reach -STEPS_PER_DETENT, the sub-count SHALL be set to 0 and step_dec SHALL assert on the next cycle.
REQ-024 Latency SHALL be exactly 1 cycle from the accepted-level change that completes a detent to the step pulse.
REQ-025 step_inc, step_dec and quad_err SHALL be mutually exclusive and SHALL never be high for two consecutive cycles.
REQ-026 position SHALL increment on step_inc and decrement on step_dec, in the same cycle as the pulse, modulo 32 (31->0 on increment, 0->31 on decrement).
REQ-027 dir_led[1] SHALL load a hold counter with LED_HOLD_CYCLES on step_inc and remain high until that counter reaches 0.
REQ-028 dir_led[0] SHALL behave the same way on step_dec.
REQ-029 A step in the opposite direction SHALL immediately clear the other LED.
REQ-030 A repeated step in the same direction SHALL reload that LED's hold counter.

Reset
REQ-031 While reset is high, all synchronizer flops, accepted levels, debounce counters, sub-count, position and LED hold counters SHALL be 0.
REQ-032 While reset is high, step_inc, step_dec, quad_err and dir_led SHALL be 0.
REQ-033 Reset asserted mid-detent SHALL discard the partial sub-count, and no step SHALL be emitted for the interrupted motion.
REQ-034 After reset releases with inputs held at 11, the accepted levels SHALL reach 11 after the debounce time, and this first settling (00->11, both bits changing) SHALL pulse quad_err once and emit no step.

Structure
REQ-035 A shared package SHALL hold the DB_CYCLES, STEPS_PER_DETENT and LED_HOLD_CYCLES defaults and the quadrature state encodings.
REQ-036 One sub-module, knob_debounce_filter (synchronizer plus stability counter, one channel), SHALL be instantiated twice.
REQ-037 The outputs step_inc and step_dec SHALL connect directly to the cursor-motion inputs of the trace display stage.

Verification (bench uses DB_CYCLES=4, LED_HOLD_CYCLES=16)
REQ-038 A clean clockwise sequence of 01,11,10,00, each level held 10 cycles, starting from settled 00 SHALL produce exactly one step_inc 1 cycle after the 00 is accepted, with position 0->1 and dir_led=10.
REQ-039 Two full counter-clockwise detents from position 0 SHALL produce two step_dec pulses, with position ending at 30 and dir_led=01.
REQ-040 Chatter on knob_a toggling every 2 cycles for 40 cycles, then settling, SHALL change no accepted level during the chatter and produce no step or quad_err.
REQ-041 Jumping the inputs 00->11 in one cycle and holding SHALL produce exactly one quad_err pulse, with sub-count 0 and position unchanged.
REQ-042 Three clockwise transitions followed by reset for 1 cycle and then the fourth transition SHALL produce no step_inc, with position remaining 0.
REQ-043 A single clockwise detent followed by 20 idle cycles SHALL hold dir_led[1] high for exactly 16 cycles after step_inc and then return it to 0.
